// File: rtl/relational_compare_stream_pkg.sv
// Shared encodings for the relational compare stream.
// Op codes line up with flag bit positions so result is a direct pick.
package relational_pkg;

   localparam int NFLG = 6;

   localparam logic [2:0] OP_GT = 3'd0;
   localparam logic [2:0] OP_LT = 3'd1;
   localparam logic [2:0] OP_GE = 3'd2;
   localparam logic [2:0] OP_LE = 3'd3;
   localparam logic [2:0] OP_EQ = 3'd4;
   localparam logic [2:0] OP_NE = 3'd5;

   localparam int FLG_GT = 0;
   localparam int FLG_LT = 1;
   localparam int FLG_GE = 2;
   localparam int FLG_LE = 3;
   localparam int FLG_EQ = 4;
   localparam int FLG_NE = 5;

   function automatic logic op_bad(input logic [2:0] op);
      return op > OP_NE;
   endfunction

   function automatic logic sel_flag(
      input logic [NFLG-1:0] f,
      input logic [2:0]      op
   );
      logic r;
      r = 1'b0;
      case (op)
         OP_GT:   r = f[FLG_GT];
         OP_LT:   r = f[FLG_LT];
         OP_GE:   r = f[FLG_GE];
         OP_LE:   r = f[FLG_LE];
         OP_EQ:   r = f[FLG_EQ];
         OP_NE:   r = f[FLG_NE];
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/relational_compare_stream_core.sv
// Combinational six-way relation of two WIDTH-bit operands.
// Signed mode flips the sign bits so one magnitude compare serves both.
module relational_core
   import relational_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic [NFLG-1:0]  flags
);

   logic [WIDTH-1:0] ab;
   logic [WIDTH-1:0] bb;
   logic             lt;
   logic             eq;

   assign ab = {a[WIDTH-1] ^ is_signed, a[WIDTH-2:0]};
   assign bb = {b[WIDTH-1] ^ is_signed, b[WIDTH-2:0]};
   assign lt = ab < bb;
   assign eq = a == b;

   assign flags[FLG_GT] = !lt && !eq;
   assign flags[FLG_LT] = lt;
   assign flags[FLG_GE] = !lt;
   assign flags[FLG_LE] = lt || eq;
   assign flags[FLG_EQ] = eq;
   assign flags[FLG_NE] = !eq;

endmodule

// File: rtl/relational_compare_stream.sv
// Two-stage valid/ready relational comparator with a saturating
// count of delivered true results.
module relational_compare_stream
   import relational_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [2:0]           op,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 result,
   output logic [NFLG-1:0]      flags,
   output logic                 op_err,
   input  logic                 clr_cnt,
   output logic [CNT_WIDTH-1:0] match_cnt
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [2:0]       s1_op;
   logic             s1_sg;
   logic [NFLG-1:0]  s1_flags;

   logic in_fire;
   logic out_fire;
   logic s2_adv;

   relational_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .a         (s1_a),
      .b         (s1_b),
      .is_signed (s1_sg),
      .flags     (s1_flags)
   );

   assign out_fire = out_valid && out_ready;
   assign s2_adv   = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || s2_adv;
   assign in_fire  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
         s1_sg    <= 1'b0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_a     <= a;
         s1_b     <= b;
         s1_op    <= op;
         s1_sg    <= is_signed;
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // Payload only moves on a load, so it holds steady through a stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= 1'b0;
         flags     <= '0;
         op_err    <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= 1'b1;
         result    <= sel_flag(s1_flags, s1_op);
         flags     <= s1_flags;
         op_err    <= op_bad(s1_op);
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         match_cnt <= '0;
      end else if (out_fire && result && !(&match_cnt)) begin
         match_cnt <= match_cnt + 1'b1;
      end
   end

endmodule

// File: doc/relational_compare_stream.md
Name: relational_compare_stream

Overview:
- Parametrised, pipelined successor to the fixed 4-bit relational comparator.
- Takes a stream of operand pairs (a, b) with a per-transaction operation select and signed/unsigned mode.
- Returns the selected relation result plus all six relation flags, under valid/ready handshakes on both sides.
- Keeps a saturating count of true results for datapath monitoring; sits between operand-producing datapaths and control logic that needs registered compare outcomes.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- CNT_WIDTH, 16, width of the match counter (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair and op presented.
- in_ready  out  1  block accepts the transaction this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  relation select; encodings in package.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result registered and presented.
- out_ready  in  1  downstream accepts the result.
- result  out  1  value of the selected relation.
- flags  out  6  {ne, eq, le, ge, lt, gt}, bit 0 = gt.
- op_err  out  1  op was an illegal encoding (6 or 7).
- clr_cnt  in  1  synchronous clear of match_cnt.
- match_cnt  out  CNT_WIDTH  count of delivered results equal to 1.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: out_valid=0, result=0, flags=0, op_err=0, match_cnt=0, both pipeline stages empty. in_ready may be 1 in the cycle after reset.
- Op encoding:
  - 0 GT, 1 LT, 2 GE, 3 LE, 4 EQ, 5 NE.
  - 6 and 7 are illegal: result=0, op_err=1, flags still computed.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage 1 (s1):
  - Registers a, b, op, is_signed and the valid bit.
  - Computes lt and eq combinationally from the registered operands.
  - Signed mode compares as two's complement; unsigned compares as magnitude.
- Stage 2 (s2):
  - Registers flags derived from lt/eq: gt=!lt&&!eq, ge=!lt, le=lt||eq, ne=!eq.
  - Registers result = flags bit selected by op, and op_err.
  - s2 is the output register, so out_valid = s2 valid.
- Advance rules:
  - s2 loads when s1 is valid and (s2 empty or output transfer this cycle).
  - s1 loads when an input transfer occurs.
  - in_ready = !s1_valid || s1 advancing into s2. This is a combinational function of out_ready; no combinational path from in_valid to in_ready.
- Latency and throughput: 2 cycles from input transfer to out_valid with no stall. Full throughput is 1 transaction/cycle when out_ready is held high.
- Stall: with out_ready=0 the pipeline holds 2 transactions, then in_ready=0.
  - Output payload stays stable while out_valid=1 and out_ready=0.
  - No transaction is lost or duplicated.
- match_cnt:
  - Increments by 1 on each output transfer with result=1.
  - Saturates at all-ones and does not wrap.
  - clr_cnt=1 forces match_cnt to 0 next cycle; clear wins over a simultaneous increment.
- Width rules:
  - All operand arithmetic is done at WIDTH bits.
  - Signed compare uses the MSB as the sign bit, e.g. WIDTH=4: 4'b1000 = -8 < 4'b0111 = 7.
- Reset mid-operation: in-flight transactions are discarded and outputs return to reset values; no partial result is emitted.

Decomposition:
- Shared package relational_pkg holds:
  - Op encoding constants OP_GT..OP_NE.
  - Flag bit index constants FLG_GT..FLG_NE.
  - Flag vector width constant (6).
- One sub-module, relational_core: purely combinational, parametrised WIDTH. Inputs a, b, is_signed; outputs the 6-bit flags. Instantiated in s1/s2; reusable elsewhere.

Test Plan:
- WIDTH=4, unsigned, a=4'b1000, b=4'b0001, op=GT, out_ready=1 -> 2 cycles later out_valid=1, result=1, flags=6'b100101, match_cnt=1.
- Same operands with is_signed=1, op=GT -> result=0, flags=6'b101010 (-8<1); match_cnt unchanged.
- a=b=5, ops EQ, NE, then op=7 on consecutive cycles -> results 1, 0, 0; op_err only on the third; flags=6'b011100 on all three.
- Back-to-back 10 transactions with out_ready=0 from cycle 3 -> in_ready drops after 2 accepted; release out_ready -> all 10 results delivered in order, payload stable during stall.
- CNT_WIDTH=2, 5 true results -> match_cnt 1,2,3,3,3; clr_cnt asserted with a true result in the same cycle -> match_cnt=0.
- rst pulsed with both stages full -> next cycle out_valid=0, match_cnt=0; no stale result appears afterwards.
